// File: rtl/acc_exec_unit.sv
// -----------------------------------------------------------------------------
// acc_exec_unit
//   Accumulator/sequencer stage that sits directly in front of the 8-bit
//   combinational ALU. It accepts one instruction per VALID/READY handshake and
//   fetches the operand from the register file or from the immediate. It then
//   presents registered operands and opcode to the ALU, and writes the ALU
//   result back into ACC/CY/Z. It also executes ST (ACC -> register) itself,
//   because the ALU has no store operation.
//
//   Instruction word: [11:9] op, [8] imm, [7:0] immediate or [2:0] reg index.
//   Ops: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 NOT, 6 LD, 7 ST.
//   Sequence IDLE -> EXEC -> DONE -> IDLE, so at most one instruction retires
//   every 3 cycles.
//
// Parameters
//   REG_CNT          implemented GP registers R0..R(REG_CNT-1), legal 2..8
//
// Ports
//   IN_CLK           clock, rising edge
//   IN_RST_N         asynchronous active-low reset
//   IN_INSTR         12-bit instruction
//   IN_INSTR_VALID   instruction present
//   OUT_INSTR_READY  unit can accept (high only in IDLE)
//   OUT_ALU_A/R/OP   accumulator, latched operand, latched op -> ALU
//   IN_ALU_A/CY      ALU result and carry
//   OUT_ACC/CY/Z     architectural accumulator and flags
//   OUT_DONE         one-cycle retire pulse
//
// Optional build macro
//   EXEC_DBG_PORT_EN adds IN_DBG_IDX / OUT_DBG_DATA. This is a side-effect-free
//                    combinational register-file read. Out-of-range indices
//                    read 0x00.
// -----------------------------------------------------------------------------
module acc_exec_unit #(
    parameter int REG_CNT = 8
) (
    input  logic        IN_CLK,
    input  logic        IN_RST_N,
    input  logic [11:0] IN_INSTR,
    input  logic        IN_INSTR_VALID,
    output logic        OUT_INSTR_READY,
    output logic [7:0]  OUT_ALU_A,
    output logic [7:0]  OUT_ALU_R,
    output logic [2:0]  OUT_ALU_OP,
    input  logic [7:0]  IN_ALU_A,
    input  logic        IN_ALU_CY,
    output logic [7:0]  OUT_ACC,
    output logic        OUT_CY,
    output logic        OUT_Z,
    output logic        OUT_DONE
`ifdef EXEC_DBG_PORT_EN
   ,input  logic [2:0]  IN_DBG_IDX,
    output logic [7:0]  OUT_DBG_DATA
`endif
);

    localparam logic [2:0] OP_ST   = 3'd7;
    localparam logic [3:0] REG_LIM = 4'(REG_CNT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        ready_q;
    logic        done_q;
    logic [2:0]  op_q;
    logic        imm_q;
    logic [2:0]  idx_q;
    logic [7:0]  opnd_q;
    logic [7:0]  acc_q, acc_d;
    logic        cy_q,  cy_d;
    logic        z_q,   z_d;
    logic        rf_we;

    // The array is always 8 deep. Entries at or above REG_CNT are never
    // written, so they stay at their reset value and synthesis folds them
    // away. Reads of those entries are forced to 0 anyway.
    logic [7:0]  rf_q [8];
    logic [7:0]  rd_data;

    function automatic logic in_range(input logic [2:0] idx);
        return ({1'b0, idx} < REG_LIM);
    endfunction

    // Operand fetch for the instruction currently being offered.
    always_comb begin
        rd_data = 8'h00;
        if (in_range(IN_INSTR[2:0])) rd_data = rf_q[IN_INSTR[2:0]];
    end

    // Write-back during EXEC. ALU ops take the ALU outputs verbatim. ST leaves
    // the flags alone and stores to the register file only for a register
    // form whose index is in range.
    always_comb begin
        acc_d = acc_q;
        cy_d  = cy_q;
        z_d   = z_q;
        rf_we = 1'b0;
        if (state_q == S_EXEC) begin
            if (op_q != OP_ST) begin
                acc_d = IN_ALU_A;
                cy_d  = IN_ALU_CY;
                z_d   = (IN_ALU_A == 8'h00);
            end else begin
                rf_we = !imm_q && in_range(idx_q);
            end
        end
    end

    always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
        if (!IN_RST_N) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            op_q    <= 3'd0;
            imm_q   <= 1'b0;
            idx_q   <= 3'd0;
            opnd_q  <= 8'h00;
            acc_q   <= 8'h00;
            cy_q    <= 1'b0;
            z_q     <= 1'b1;
            for (int i = 0; i < 8; i++) rf_q[i] <= 8'h00;
        end else begin
            acc_q <= acc_d;
            cy_q  <= cy_d;
            z_q   <= z_d;
            if (rf_we) rf_q[idx_q] <= acc_q;

            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (IN_INSTR_VALID && ready_q) begin
                        op_q    <= IN_INSTR[11:9];
                        imm_q   <= IN_INSTR[8];
                        idx_q   <= IN_INSTR[2:0];
                        opnd_q  <= IN_INSTR[8] ? IN_INSTR[7:0] : rd_data;
                        ready_q <= 1'b0;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // The retire pulse is registered, so it shows up in the
                    // DONE cycle together with the updated ACC/flags.
                    done_q  <= 1'b1;
                    ready_q <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign OUT_INSTR_READY = ready_q;
    assign OUT_ALU_A       = acc_q;
    assign OUT_ALU_R       = opnd_q;
    assign OUT_ALU_OP      = op_q;
    assign OUT_ACC         = acc_q;
    assign OUT_CY          = cy_q;
    assign OUT_Z           = z_q;
    assign OUT_DONE        = done_q;

`ifdef EXEC_DBG_PORT_EN
    // Reads come straight from the flops, so a read concurrent with an ST
    // returns the value from before the write.
    always_comb begin
        OUT_DBG_DATA = 8'h00;
        if (in_range(IN_DBG_IDX)) OUT_DBG_DATA = rf_q[IN_DBG_IDX];
    end
`endif

endmodule
